// File: rtl/ahbl_reg_mac_engine.sv
// Int8 dot-product / saturating accumulate engine fed from the S0 register slave.
// Each STEP toggle pushes LANES signed int8 pairs through a multiply stage,
// a lane-sum stage and a saturating accumulate stage.
//
// Step handshake: CTRL_REG[2] is a toggle. A step is accepted on any edge where
// EN=1, CLR=0 and the toggle differs from its value at the previous edge. The
// toggle is tracked every cycle, so one rejected while EN=0 or CLR=1 is lost,
// not held back. Accepted steps travel as valid bits v1 -> v2 -> v3. The
// pipeline never stalls, so one step per cycle is always accepted. CLR drops
// every valid bit in flight.
module ahbl_reg_mac_engine #(
    parameter int LANES = 4,
    parameter int ACC_W = 32
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic [31:0]      CTRL_REG,
    input  logic [31:0]      A_REG,
    input  logic [31:0]      B_REG,
    output logic [ACC_W-1:0] ACC,
    output logic [15:0]      STEP_COUNT,
    output logic             BUSY,
    output logic             OVF
);

    logic en;
    logic clr;
    logic step_evt;

    logic                    step_q;
    logic                    v1_q;
    logic                    v2_q;
    logic                    v3_q;
    logic signed [15:0]      prod_d [LANES];
    logic signed [15:0]      prod_q [LANES];
    logic        [17:0]      sum_d;
    logic        [17:0]      sum_q;
    logic        [ACC_W:0]   acc_sum;
    logic        [ACC_W-1:0] acc_d;
    logic        [ACC_W-1:0] acc_q;
    logic        [15:0]      cnt_d;
    logic        [15:0]      cnt_q;
    logic                    ovf_d;
    logic                    ovf_q;

    assign en       = CTRL_REG[0];
    assign clr      = CTRL_REG[1];
    assign step_evt = en & ~clr & (CTRL_REG[2] != step_q);

    // Bits that carry no meaning for this block.
    logic unused_ctrl;
    assign unused_ctrl = ^CTRL_REG[31:3];

    if (LANES * 8 < 32) begin : g_unused_hi
        logic unused_hi;
        assign unused_hi = ^{A_REG[31:LANES*8], B_REG[31:LANES*8]};
    end

    // Track the toggle every cycle, reset included, so reset release never looks like a step.
    always_ff @(posedge HCLK) begin
        step_q <= CTRL_REG[2];
    end

    // Stage 1 products: each lane sign-extended to 16 bits before multiplying.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod_d[i] = $signed({{8{A_REG[8*i+7]}}, A_REG[8*i +: 8]})
                      * $signed({{8{B_REG[8*i+7]}}, B_REG[8*i +: 8]});
        end
    end

    // Operand capture only on an accepted step; later A/B changes are invisible.
    always_ff @(posedge HCLK) begin
        if (step_evt) begin
            for (int i = 0; i < LANES; i++) begin
                prod_q[i] <= prod_d[i];
            end
        end
    end

    // Stage 2 lane sum. 18 bits holds four products of up to 2^14 without wrap.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_d = sum_d + {{2{prod_q[i][15]}}, prod_q[i]};
        end
    end

    // Lane sum register, loaded only behind a valid stage-1 step.
    always_ff @(posedge HCLK) begin
        if (v1_q) begin
            sum_q <= sum_d;
        end
    end

    // Stage 3 next state: one guard bit exposes overflow, which clamps toward its sign.
    always_comb begin
        acc_sum = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-17){sum_q[17]}}, sum_q};
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (v2_q) begin
            cnt_d = cnt_q + 16'd1;
            if (acc_sum[ACC_W] != acc_sum[ACC_W-1]) begin
                ovf_d = 1'b1;
                acc_d = acc_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                       : {1'b0, {(ACC_W-1){1'b1}}};
            end else begin
                acc_d = acc_sum[ACC_W-1:0];
            end
        end
    end

    // Valid pipeline and accumulator state. CLR acts like reset and beats a stage-3 update.
    always_ff @(posedge HCLK) begin
        if (HRESET || clr) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            v1_q  <= step_evt;
            v2_q  <= v1_q;
            v3_q  <= v2_q;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign ACC        = acc_q;
    assign STEP_COUNT = cnt_q;
    assign OVF        = ovf_q;
    assign BUSY       = v1_q | v2_q | v3_q;

endmodule

// File: tb/tb_ahbl_reg_mac_engine.sv
// Bench for ahbl_reg_mac_engine: ACC_W=32 and ACC_W=20 instances share stimulus.
// Reference model: plain integer dot products, clamped by width, landing two edges after issue.
module tb_ahbl_reg_mac_engine;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [31:0] CTRL_REG;
    logic [31:0] A_REG;
    logic [31:0] B_REG;
    logic [31:0] acc32;
    logic [19:0] acc20;
    logic [15:0] cnt32;
    logic [15:0] cnt20;
    logic        busy32;
    logic        busy20;
    logic        ovf32;
    logic        ovf20;

    // Clock generation.
    always #5 HCLK = ~HCLK;

    ahbl_reg_mac_engine #(.LANES(4), .ACC_W(32)) dut32 (
        .HCLK(HCLK), .HRESET(HRESET), .CTRL_REG(CTRL_REG), .A_REG(A_REG), .B_REG(B_REG),
        .ACC(acc32), .STEP_COUNT(cnt32), .BUSY(busy32), .OVF(ovf32)
    );

    ahbl_reg_mac_engine #(.LANES(4), .ACC_W(20)) dut20 (
        .HCLK(HCLK), .HRESET(HRESET), .CTRL_REG(CTRL_REG), .A_REG(A_REG), .B_REG(B_REG),
        .ACC(acc20), .STEP_COUNT(cnt20), .BUSY(busy20), .OVF(ovf20)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;
    int last_evt;
    bit step_bit;

    // Model state at issue time.
    longint m_acc32, m_acc20;
    int     m_cnt;
    bit     m_ovf32, m_ovf20;

    // Values expected on the outputs now.
    longint vis_acc32, vis_acc20;
    int     vis_cnt;
    bit     vis_ovf32, vis_ovf20, vis_busy;

    typedef struct {
        int     due;
        longint a32;
        longint a20;
        int     cnt;
        bit     o32;
        bit     o20;
    } exp_t;
    exp_t exp_q[$];

    function automatic longint dot(input logic [31:0] a, input logic [31:0] b);
        longint s;
        byte    sa;
        byte    sb;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            sa = a[8*i +: 8];
            sb = b[8*i +: 8];
            s += longint'(sa) * longint'(sb);
        end
        return s;
    endfunction

    function automatic longint clamp(input longint v, input int w);
        longint hi;
        longint lo;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -(longint'(1) << (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic model_clear();
        m_acc32 = 0; m_acc20 = 0; m_cnt = 0; m_ovf32 = 0; m_ovf20 = 0;
        vis_acc32 = 0; vis_acc20 = 0; vis_cnt = 0; vis_ovf32 = 0; vis_ovf20 = 0;
        exp_q.delete();
        last_evt = -1000;
    endtask

    // Drive one cycle of inputs, step the model across the edge, return at the next negedge.
    task automatic drive_cycle(input bit en, input bit clr, input bit tog,
                               input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint d;
        longint r;
        if (tog) step_bit = ~step_bit;
        CTRL_REG = {29'd0, step_bit, clr, en};
        A_REG    = a;
        B_REG    = b;
        @(posedge HCLK);
        cyc++;
        if (clr) begin
            model_clear();
        end else if (en && tog) begin
            d = dot(a, b);
            r = m_acc32 + d;
            m_acc32 = clamp(r, 32);
            if (m_acc32 != r) m_ovf32 = 1;
            r = m_acc20 + d;
            m_acc20 = clamp(r, 20);
            if (m_acc20 != r) m_ovf20 = 1;
            m_cnt = (m_cnt + 1) & 32'hFFFF;
            e.due = cyc + 2; e.a32 = m_acc32; e.a20 = m_acc20;
            e.cnt = m_cnt;   e.o32 = m_ovf32; e.o20 = m_ovf20;
            exp_q.push_back(e);
            last_evt = cyc;
        end
        while (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            vis_acc32 = e.a32; vis_acc20 = e.a20; vis_cnt = e.cnt;
            vis_ovf32 = e.o32; vis_ovf20 = e.o20;
        end
        vis_busy = (cyc - last_evt) <= 2;
        @(negedge HCLK);
    endtask

    task automatic test_reset();
        HRESET = 1'b1; step_bit = 1'b1;
        CTRL_REG = 32'h4; A_REG = $urandom; B_REG = $urandom;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        n_tests++; if (acc32 !== 32'd0 || acc20 !== 20'd0) begin n_fail++; $display("FAIL reset_acc got=%0h/%0h exp=0", acc32, acc20); end
        n_tests++; if (cnt32 !== 16'd0 || cnt20 !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got=%0h/%0h exp=0", cnt32, cnt20); end
        n_tests++; if (busy32 !== 1'b0 || busy20 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b/%b exp=0", busy32, busy20); end
        n_tests++; if (ovf32 !== 1'b0 || ovf20 !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b/%b exp=0", ovf32, ovf20); end
        HRESET = 1'b0;
        cyc = 0;
        model_clear();
        for (int j = 0; j < 4; j++) begin
            drive_cycle(1'b1, 1'b0, 1'b0, $urandom, $urandom);
            n_tests++; if (busy32 !== 1'b0 || acc32 !== 32'd0 || cnt32 !== 16'd0) begin
                n_fail++; $display("FAIL release_idle j=%0d got busy=%b acc=%0h cnt=%0d exp busy=0 acc=0 cnt=0", j, busy32, acc32, cnt32);
            end
        end
    endtask

    task automatic test_single_step();
        for (int j = 0; j < 4; j++) begin
            drive_cycle(1'b1, 1'b0, j == 0, (j == 0) ? 32'h01020304 : $urandom,
                        (j == 0) ? 32'h01010101 : $urandom);
            n_tests++; if (busy32 !== (j < 3)) begin n_fail++; $display("FAIL single_busy j=%0d got=%b exp=%b", j, busy32, j < 3); end
            n_tests++; if (acc32 !== ((j >= 2) ? 32'd10 : 32'd0)) begin n_fail++; $display("FAIL single_acc j=%0d got=%0d exp=%0d", j, acc32, (j >= 2) ? 10 : 0); end
        end
        n_tests++; if (cnt32 !== 16'd1) begin n_fail++; $display("FAIL single_cnt got=%0d exp=1", cnt32); end
    endtask

    task automatic test_negative();
        drive_cycle(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        drive_cycle(1'b1, 1'b0, 1'b1, 32'h80808080, 32'h7F7F7F7F);
        repeat (2) drive_cycle(1'b1, 1'b0, 1'b0, $urandom, $urandom);
        n_tests++; if (acc32 !== 32'hFFFF0200) begin n_fail++; $display("FAIL neg_acc32 got=%0h exp=ffff0200", acc32); end
        n_tests++; if (acc20 !== 20'hF0200) begin n_fail++; $display("FAIL neg_acc20 got=%0h exp=f0200", acc20); end
        n_tests++; if (ovf32 !== 1'b0 || ovf20 !== 1'b0 || cnt32 !== 16'd1) begin
            n_fail++; $display("FAIL neg_flags got ovf=%b/%b cnt=%0d exp ovf=0/0 cnt=1", ovf32, ovf20, cnt32);
        end
    endtask

    task automatic test_back_to_back();
        int exp_acc;
        drive_cycle(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        for (int j = 0; j < 8; j++) begin
            drive_cycle(1'b1, 1'b0, j < 5, 32'h00000002, 32'h00000003);
            exp_acc = (j < 2) ? 0 : ((j - 1 > 5) ? 5 : j - 1) * 6;
            n_tests++; if (acc32 !== 32'(exp_acc) || acc20 !== 20'(exp_acc)) begin
                n_fail++; $display("FAIL b2b_acc j=%0d got=%0d/%0d exp=%0d", j, acc32, acc20, exp_acc);
            end
        end
        n_tests++; if (cnt32 !== 16'd5) begin n_fail++; $display("FAIL b2b_cnt got=%0d exp=5", cnt32); end
        for (int j = 0; j < 8; j++) drive_cycle(1'b0, 1'b0, j < 5, 32'h00000002, 32'h00000003);
        n_tests++; if (acc32 !== 32'd30 || cnt32 !== 16'd5 || busy32 !== 1'b0) begin
            n_fail++; $display("FAIL b2b_en0 got acc=%0d cnt=%0d busy=%b exp acc=30 cnt=5 busy=0", acc32, cnt32, busy32);
        end
    endtask

    task automatic test_saturation();
        drive_cycle(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        for (int j = 0; j < 8; j++) drive_cycle(1'b1, 1'b0, 1'b1, 32'h80808080, 32'h80808080);
        repeat (3) drive_cycle(1'b1, 1'b0, 1'b0, $urandom, $urandom);
        n_tests++; if (acc20 !== 20'h7FFFF || ovf20 !== 1'b1) begin n_fail++; $display("FAIL sat_hi20 got acc=%0h ovf=%b exp acc=7ffff ovf=1", acc20, ovf20); end
        n_tests++; if (acc32 !== 32'd524288 || ovf32 !== 1'b0) begin n_fail++; $display("FAIL sat_hi32 got acc=%0d ovf=%b exp acc=524288 ovf=0", acc32, ovf32); end
        drive_cycle(1'b1, 1'b0, 1'b1, 32'h80808080, 32'h7F7F7F7F);
        repeat (3) drive_cycle(1'b1, 1'b0, 1'b0, $urandom, $urandom);
        n_tests++; if (acc20 !== 20'd459263 || ovf20 !== 1'b1) begin n_fail++; $display("FAIL sat_back20 got acc=%0d ovf=%b exp acc=459263 ovf=1", acc20, ovf20); end
        n_tests++; if (acc32 !== 32'd459264) begin n_fail++; $display("FAIL sat_back32 got=%0d exp=459264", acc32); end
        drive_cycle(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        n_tests++; if (ovf20 !== 1'b0 || acc20 !== 20'd0) begin n_fail++; $display("FAIL sat_clr got acc=%0d ovf=%b exp acc=0 ovf=0", acc20, ovf20); end
        for (int j = 0; j < 9; j++) drive_cycle(1'b1, 1'b0, 1'b1, 32'h80808080, 32'h7F7F7F7F);
        repeat (3) drive_cycle(1'b1, 1'b0, 1'b0, $urandom, $urandom);
        n_tests++; if (acc20 !== 20'h80000 || ovf20 !== 1'b1) begin n_fail++; $display("FAIL sat_lo20 got acc=%0h ovf=%b exp acc=80000 ovf=1", acc20, ovf20); end
        n_tests++; if ($signed(acc32) !== -585216 || ovf32 !== 1'b0) begin n_fail++; $display("FAIL sat_lo32 got acc=%0d ovf=%b exp acc=-585216 ovf=0", $signed(acc32), ovf32); end
    endtask

    task automatic test_clr_midflight();
        drive_cycle(1'b1, 1'b0, 1'b1, 32'h01020304, 32'h01010101);
        drive_cycle(1'b1, 1'b1, 1'b0, $urandom, $urandom);
        n_tests++; if (acc32 !== 32'd0 || acc20 !== 20'd0 || cnt32 !== 16'd0) begin
            n_fail++; $display("FAIL clr_state got acc=%0h/%0h cnt=%0d exp 0", acc32, acc20, cnt32);
        end
        n_tests++; if (ovf32 !== 1'b0 || ovf20 !== 1'b0 || busy32 !== 1'b0) begin
            n_fail++; $display("FAIL clr_flags got ovf=%b/%b busy=%b exp 0", ovf32, ovf20, busy32);
        end
        drive_cycle(1'b1, 1'b1, 1'b1, 32'h01010101, 32'h01010101);
        for (int j = 0; j < 3; j++) begin
            drive_cycle(1'b1, 1'b0, 1'b0, $urandom, $urandom);
            n_tests++; if (acc32 !== 32'd0 || cnt32 !== 16'd0 || busy32 !== 1'b0) begin
                n_fail++; $display("FAIL clr_after j=%0d got acc=%0h cnt=%0d busy=%b exp 0", j, acc32, cnt32, busy32);
            end
        end
    endtask

    task automatic test_en_fall();
        drive_cycle(1'b1, 1'b0, 1'b1, 32'h00000004, 32'h00000005);
        drive_cycle(1'b0, 1'b0, 1'b1, 32'h00000007, 32'h00000007);
        repeat (4) drive_cycle(1'b1, 1'b0, 1'b0, $urandom, $urandom);
        n_tests++; if (acc32 !== 32'd20 || cnt32 !== 16'd1 || busy32 !== 1'b0) begin
            n_fail++; $display("FAIL en_fall got acc=%0d cnt=%0d busy=%b exp acc=20 cnt=1 busy=0", acc32, cnt32, busy32);
        end
    endtask

    task automatic test_random();
        bit          en, clr, tog;
        logic [31:0] a, b;
        for (int j = 0; j < 400; j++) begin
            en  = $urandom_range(0, 3) != 0;
            clr = $urandom_range(0, 63) == 0;
            tog = $urandom_range(0, 1) == 1;
            a   = $urandom;
            b   = ($urandom_range(0, 1) == 1) ? a : $urandom;
            drive_cycle(en, clr, tog, a, b);
            n_tests++; if (acc32 !== 32'(vis_acc32)) begin n_fail++; $display("FAIL rand_acc32 cyc=%0d got=%0h exp=%0h", cyc, acc32, 32'(vis_acc32)); end
            n_tests++; if (acc20 !== 20'(vis_acc20)) begin n_fail++; $display("FAIL rand_acc20 cyc=%0d got=%0h exp=%0h", cyc, acc20, 20'(vis_acc20)); end
            n_tests++; if (cnt32 !== 16'(vis_cnt) || cnt20 !== 16'(vis_cnt)) begin n_fail++; $display("FAIL rand_cnt cyc=%0d got=%0d/%0d exp=%0d", cyc, cnt32, cnt20, vis_cnt); end
            n_tests++; if (ovf32 !== vis_ovf32 || ovf20 !== vis_ovf20) begin n_fail++; $display("FAIL rand_ovf cyc=%0d got=%b/%b exp=%b/%b", cyc, ovf32, ovf20, vis_ovf32, vis_ovf20); end
            n_tests++; if (busy32 !== vis_busy || busy20 !== vis_busy) begin n_fail++; $display("FAIL rand_busy cyc=%0d got=%b/%b exp=%b", cyc, busy32, busy20, vis_busy); end
        end
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_negative();
        test_back_to_back();
        test_saturation();
        test_clr_midflight();
        test_en_fall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
